// File: rtl/lsu_pkg.sv
// Shared constants and types for the RV32I load/store unit.
// Opcodes, funct3 codes, FSM states and an alignment helper.
package lsu_pkg;

  localparam int XLEN = 32;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE
  } lsu_state_e;

  // funct3[1:0] encodes access size for loads and stores alike.
  function automatic logic misaligned(
    input logic [2:0] f3,
    input logic [1:0] off
  );
    logic m;
    m = 1'b0;
    unique case (1'b1)
      f3[1:0] == 2'b01: m = off[0];
      f3[1:0] == 2'b10: m = |off;
      default:          m = 1'b0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane steering: store strobes/replicated data and load extract/extend.
// Ports: funct3_i, off_i, wdata_i, mem_rdata_i -> wstrb_o, wdata_o, rdata_o.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]      funct3_i,
  input  logic [1:0]      off_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic [XLEN-1:0] mem_rdata_i,
  output logic [3:0]      wstrb_o,
  output logic [XLEN-1:0] wdata_o,
  output logic [XLEN-1:0] rdata_o
);

  logic [XLEN-1:0] sh;

  // Bring the addressed lane down to bit 0.
  assign sh = mem_rdata_i >> {off_i, 3'b000};

  always_comb begin
    wstrb_o = 4'b0000;
    wdata_o = '0;
    unique case (1'b1)
      funct3_i[1:0] == 2'b00: begin
        wstrb_o = 4'b0001 << off_i;
        wdata_o = {4{wdata_i[7:0]}};
      end
      funct3_i[1:0] == 2'b01: begin
        wstrb_o = 4'b0011 << off_i;
        wdata_o = {2{wdata_i[15:0]}};
      end
      funct3_i[1:0] == 2'b10: begin
        wstrb_o = 4'b1111;
        wdata_o = wdata_i;
      end
      default: begin
        wstrb_o = 4'b0000;
        wdata_o = '0;
      end
    endcase
  end

  always_comb begin
    rdata_o = '0;
    unique case (1'b1)
      funct3_i == F3_B:  rdata_o = {{24{sh[7]}}, sh[7:0]};
      funct3_i == F3_H:  rdata_o = {{16{sh[15]}}, sh[15:0]};
      funct3_i == F3_W:  rdata_o = mem_rdata_i;
      funct3_i == F3_BU: rdata_o = {24'd0, sh[7:0]};
      funct3_i == F3_HU: rdata_o = {16'd0, sh[15:0]};
      default:           rdata_o = '0;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: core req/resp handshake to memory gnt/rvalid.
// Ports: req_*/inst/addr/wdata in, resp_*/rdata out, mem_* bus.
module lsu
  import lsu_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [31:0]     inst,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] wdata,
  output logic            resp_valid,
  output logic            resp_err,
  output logic [XLEN-1:0] rdata,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [3:0]      mem_wstrb,
  output logic [XLEN-1:0] mem_wdata,
  input  logic            mem_gnt,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata
);

  lsu_state_e      state_q;
  logic [2:0]      f3_q;
  logic [1:0]      off_q;
  logic            mem_req_q;
  logic            mem_we_q;
  logic [XLEN-1:0] mem_addr_q;
  logic [3:0]      mem_wstrb_q;
  logic [XLEN-1:0] mem_wdata_q;
  logic            resp_valid_q;
  logic            resp_err_q;
  logic [XLEN-1:0] rdata_q;

  logic [6:0]      opc;
  logic [2:0]      f3;
  logic            is_ld;
  logic            is_st;
  logic            legal;
  logic            idle;
  logic [2:0]      al_f3;
  logic [1:0]      al_off;
  logic [3:0]      al_wstrb;
  logic [XLEN-1:0] al_wdata;
  logic [XLEN-1:0] al_rdata;
  logic            unused_inst;

  assign opc  = inst[6:0];
  assign f3   = inst[14:12];
  assign idle = (state_q == S_IDLE);

  assign unused_inst = ^{inst[31:15], inst[11:7]};

  always_comb begin
    is_ld = 1'b0;
    is_st = 1'b0;
    if (opc == OPC_LOAD)
      is_ld = f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
    if (opc == OPC_STORE)
      is_st = f3 inside {F3_B, F3_H, F3_W};
  end

  assign legal = (is_ld | is_st) &
                 ~misaligned(f3, addr[1:0]);

  // Store steering uses live inputs at accept time;
  // load extraction uses the captured funct3/offset.
  assign al_f3  = idle ? f3 : f3_q;
  assign al_off = idle ? addr[1:0] : off_q;

  lsu_align u_align (
    .funct3_i    (al_f3),
    .off_i       (al_off),
    .wdata_i     (wdata),
    .mem_rdata_i (mem_rdata),
    .wstrb_o     (al_wstrb),
    .wdata_o     (al_wdata),
    .rdata_o     (al_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      f3_q         <= '0;
      off_q        <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wstrb_q  <= '0;
      mem_wdata_q  <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      rdata_q      <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            f3_q  <= f3;
            off_q <= addr[1:0];
            if (legal) begin
              mem_req_q   <= 1'b1;
              mem_we_q    <= is_st;
              mem_addr_q  <= {addr[XLEN-1:2], 2'b00};
              mem_wstrb_q <= is_st ? al_wstrb : 4'b0000;
              mem_wdata_q <= is_st ? al_wdata : '0;
              state_q     <= S_REQ;
            end else begin
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
              rdata_q      <= '0;
              state_q      <= S_DONE;
            end
          end
        end
        S_REQ: begin
          if (mem_gnt) begin
            mem_req_q <= 1'b0;
            if (mem_we_q) begin
              resp_valid_q <= 1'b1;
              rdata_q      <= '0;
              state_q      <= S_DONE;
            end else begin
              state_q <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (mem_rvalid) begin
            resp_valid_q <= 1'b1;
            rdata_q      <= al_rdata;
            state_q      <= S_DONE;
          end
        end
        S_DONE: begin
          resp_valid_q <= 1'b0;
          resp_err_q   <= 1'b0;
          rdata_q      <= '0;
          state_q      <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready  = idle;
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign rdata      = rdata_q;
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wstrb  = mem_wstrb_q;
  assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_lsu.sv
// Scoreboard bench for lsu: expected responses queued at issue,
// popped and compared when resp_valid is seen.
module tb_lsu;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] inst;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] rdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  lsu dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .inst       (inst),
    .addr       (addr),
    .wdata      (wdata),
    .resp_valid (resp_valid),
    .resp_err   (resp_err),
    .rdata      (rdata),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wstrb  (mem_wstrb),
    .mem_wdata  (mem_wdata),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
  );

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   n_vec;
  int   n_err;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [6:0] o,
                                     input logic [2:0] f);
    return {17'd0, f, 5'd0, o};
  endfunction

  function automatic logic [31:0] ext(input logic [2:0] f,
                                      input logic [1:0] off,
                                      input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[8*off +: 8];
    h = (off == 2'd2) ? w[31:16] : w[15:0];
    case (f)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b010:  return w;
      3'b100:  return {24'd0, b};
      3'b101:  return {16'd0, h};
      default: return 32'd0;
    endcase
  endfunction

  task automatic run_op(input string tag,
                        input logic [31:0] ins,
                        input logic [31:0] a,
                        input logic [31:0] wd,
                        input int gd,
                        input int rd,
                        input logic [31:0] mrd);
    logic [6:0]  o;
    logic [2:0]  f;
    logic        ld, st, mis, ok;
    int          nb, gcyc;
    logic [3:0]  xs;
    logic [31:0] xw;
    exp_t        e;
    bit          granted, done, saw_req;
    o  = ins[6:0];
    f  = ins[14:12];
    ld = (o == 7'h03) &&
         (f == 3'd0 || f == 3'd1 || f == 3'd2 ||
          f == 3'd4 || f == 3'd5);
    st = (o == 7'h23) && (f <= 3'd2);
    mis = (f[1:0] == 2'd1 && a[0]) ||
          (f[1:0] == 2'd2 && a[1:0] != 2'd0);
    ok = (ld || st) && !mis;
    nb = (f[1:0] == 2'd0) ? 1 : (f[1:0] == 2'd1) ? 2 : 4;
    xs = '0;
    xw = '0;
    for (int b = 0; b < 4; b++) begin
      xs[b] = st && (b >= a[1:0]) && (b < a[1:0] + nb);
      xw[8*b +: 8] = wd[8*(b % nb) +: 8];
    end
    e.err   = !ok;
    e.rdata = (ok && ld) ? ext(f, a[1:0], mrd) : 32'd0;
    e.lat   = !ok ? 1 : st ? 2 + gd : 3 + gd + rd;
    sb.push_back(e);
    granted = 0;
    done    = 0;
    saw_req = 0;
    gcyc    = 0;
    @(negedge clk);
    chk({tag, ":ready"}, {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1;
    inst      = ins;
    addr      = a;
    wdata     = wd;
    for (int cyc = 1; cyc <= 60 && !done; cyc++) begin
      @(negedge clk);
      req_valid  = 1'b0;
      inst       = $urandom;
      addr       = $urandom;
      wdata      = $urandom;
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b0;
      mem_rdata  = $urandom;
      if (mem_req) begin
        saw_req = 1;
        if (cyc == 1 || cyc == 1 + gd) begin
          chk({tag, ":maddr"}, mem_addr, {a[31:2], 2'b00});
          chk({tag, ":we"}, {31'd0, mem_we}, {31'd0, st});
          chk({tag, ":wstrb"}, {28'd0, mem_wstrb}, {28'd0, xs});
          if (st) chk({tag, ":wdata"}, mem_wdata, xw);
        end
      end
      if (granted && cyc == gcyc + 1 + rd) begin
        mem_rvalid = 1'b1;
        mem_rdata  = mrd;
      end
      if (mem_req && !granted && cyc >= 1 + gd) begin
        mem_gnt = 1'b1;
        granted = 1;
        gcyc    = cyc;
      end
      if (resp_valid) begin
        e = sb.pop_front();
        chk({tag, ":err"}, {31'd0, resp_err}, {31'd0, e.err});
        chk({tag, ":rdata"}, rdata, e.rdata);
        chk({tag, ":lat"}, cyc, e.lat);
        done = 1;
      end
    end
    if (!done) begin
      chk({tag, ":timeout"}, 32'd0, 32'd1);
      void'(sb.pop_front());
    end
    chk({tag, ":memreq"}, {31'd0, saw_req}, {31'd0, ok});
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, ":ready"}, {31'd0, req_ready}, 32'd1);
    chk({tag, ":rv"}, {31'd0, resp_valid}, 32'd0);
    chk({tag, ":rerr"}, {31'd0, resp_err}, 32'd0);
    chk({tag, ":rdata"}, rdata, 32'd0);
    chk({tag, ":mreq"}, {31'd0, mem_req}, 32'd0);
    chk({tag, ":mwe"}, {31'd0, mem_we}, 32'd0);
    chk({tag, ":maddr"}, mem_addr, 32'd0);
    chk({tag, ":mstrb"}, {28'd0, mem_wstrb}, 32'd0);
    chk({tag, ":mwd"}, mem_wdata, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  localparam logic [6:0] LD = 7'b0000011;
  localparam logic [6:0] ST = 7'b0100011;

  initial begin
    n_vec      = 0;
    n_err      = 0;
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    inst       = '0;
    addr       = '0;
    wdata      = '0;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    repeat (2) @(negedge clk);
    chk_reset_outs("rst");
    rst_n = 1'b1;
    @(negedge clk);
    chk_reset_outs("post_rst");

    run_op("lbu", mk(LD, 3'd4), 32'h1003, 0, 0, 0, 32'h80FF_1234);
    run_op("lb",  mk(LD, 3'd0), 32'h1003, 0, 0, 0, 32'h80FF_1234);
    run_op("sh",  mk(ST, 3'd1), 32'h2002, 32'hDEAD_BEEF, 0, 0, 0);
    run_op("lw_mis", mk(LD, 3'd2), 32'h3001, 0, 0, 0, 32'h1111_2222);
    run_op("lw_wait", mk(LD, 3'd2), 32'h4000, 0, 3, 1,
           32'hCAFE_F00D);
    run_op("ld_f3_011", mk(LD, 3'd3), 32'h5000, 0, 0, 0, 32'h1);
    run_op("sb", mk(ST, 3'd0), 32'h6001, 32'h0000_00A5, 1, 0, 0);
    run_op("sw", mk(ST, 3'd2), 32'h6004, 32'h1234_5678, 0, 0, 0);
    run_op("lh", mk(LD, 3'd1), 32'h7002, 0, 0, 2, 32'h8001_7FFF);
    run_op("lhu", mk(LD, 3'd5), 32'h7002, 0, 2, 0, 32'h8001_7FFF);
    run_op("sh_mis", mk(ST, 3'd1), 32'h7003, 32'h1, 0, 0, 0);
    run_op("bad_opc", mk(7'h33, 3'd0), 32'h7000, 0, 0, 0, 0);
    run_op("st_f3_100", mk(ST, 3'd4), 32'h7000, 0, 0, 0, 0);

    for (int i = 0; i < 20; i++) begin
      logic [31:0] ri;
      ri = mk(($urandom_range(0, 1) != 0) ? LD : ST,
              3'($urandom_range(0, 7)));
      run_op($sformatf("rnd%0d", i), ri, $urandom, $urandom,
             $urandom_range(0, 3), $urandom_range(0, 2), $urandom);
    end

    // Abort a load while it waits for data.
    @(negedge clk);
    req_valid = 1'b1;
    inst      = mk(LD, 3'd2);
    addr      = 32'h8000;
    @(negedge clk);
    req_valid = 1'b0;
    mem_gnt   = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("abort:mreq", {31'd0, mem_req}, 32'd0);
    chk("abort:ready", {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h5555_AAAA;
    @(negedge clk);
    mem_rvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("abort:norv", {31'd0, resp_valid}, 32'd0);
      @(negedge clk);
    end
    chk_reset_outs("abort");

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
